thor2022_sns_tracker: RTL and testbench
=======================================

# thor2022_sns_tracker

Maintains per-slot age sequence numbers (`sns`) for the reorder buffer and feeds them to the schedule stage, which picks execute and retire candidates by lowest sequence number. Sits directly upstream of the scheduler. It consumes enqueue slots from fetch, the retire slot, and the stomp mask, and keeps sequence numbers dense: the oldest live entry is always 0. Free slots read as all-ones so they never win a "lowest sequence number" comparison.

## Interface
- `REB_ENTRIES`, 6: number of reorder-buffer slots tracked (indices 0..REB_ENTRIES-1).
- `SNW`, 6: sequence-number width; free/unused value is all-ones (6'h3F).
- `rst`  in  1  asynchronous, active-high reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `enq0`  in  1  enqueue request, port 0 (older of the pair).
- `enq0_slot`  in  3  slot for port 0 (from `next_fetch0`).
- `enq1`  in  1  enqueue request, port 1 (younger); present only with the dual-enqueue macro.
- `enq1_slot`  in  3  slot for port 1 (from `next_fetch1`).
- `ret`  in  1  retire strobe.
- `ret_slot`  in  3  slot being retired (from `next_retire`).
- `stomp`  in  8  per-slot kill mask; bits ≥ REB_ENTRIES are ignored.
- `sns`  out  6×[0:7]  sequence number per slot; slots ≥ REB_ENTRIES are tied to 6'h3F.
- `live`  out  8  per-slot occupied flags.
- `count`  out  3  number of live entries.
- `head`  out  3  slot holding sn 0; 3'd7 when empty.
- `full`  out  1  count == REB_ENTRIES.
- `empty`  out  1  count == 0.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Reset state: `live`=0, every `sns`=6'h3F, `count`=0, `head`=7, `empty`=1, `full`=0, `err`=0.
- Each cycle applies three phases in fixed order, computed combinationally from current state. The result is registered.
  - 1) **Retire.** If `ret` and `live[ret_slot]`: clear that slot and decrement every live sn greater than the retired sn. If `ret` hits a non-live slot: no state change, set `err`.
  - 2) **Stomp.** Clear every live slot whose `stomp` bit is set. Each survivor's new sn = number of surviving entries with a smaller sn (rank compaction). Order is preserved and the numbers stay dense 0..n-1.
  - 3) **Enqueue.** Let c = survivor count after phases 1 and 2. Port 0 gets sn c. Port 1 gets c+1, or c if port 0 is idle.
- Enqueue to a slot stomped or retired in the same cycle is legal and creates a fresh entry.
- Enqueue is dropped and `err` is set when:
  - the target slot is live after phases 1 and 2;
  - `enq0_slot`==`enq1_slot` with both asserted (port 1 dropped);
  - the slot index is ≥ REB_ENTRIES;
  - there is no free capacity. Capacity is checked after phases 1 and 2, so retire-plus-enqueue while full succeeds.
- Arithmetic: sns are unsigned SNW-bit values. Live values never exceed REB_ENTRIES-1, so no wrap occurs. Freed slots are written 6'h3F.
- `head` = slot whose sn is 0; `count` = popcount(`live`). Both are registered with the state.
- `err` clears only on reset.

## Timing
- All outputs are registered. An event on inputs in cycle N is visible on `sns`/`live`/`count`/`head` in cycle N+1.
- No handshake. Upstream must only enqueue into slots presented by fetch and must respect `full` from the previous cycle.
- Reset mid-operation clears all entries immediately (asynchronous). The first enqueue after deassertion gets sn 0.

## Configuration
- `THOR2022_SNS_DUAL_ENQ_EN`
  - Defined: `enq1`/`enq1_slot` ports exist and are used, allowing two enqueues per cycle.
  - Undefined: those ports are omitted, port 0 is the only enqueue path, and the port-1 duplicate check is removed.

## Structure
- Shared package holds:
  - `REB_ENTRIES`
  - `SNW`
  - the `SN_FREE` constant (all-ones)
  - a typedef for the sns array, shared by this block and the scheduler.
- One sub-module, `thor2022_sns_rank`: given the post-retire live mask, sns, and stomp mask, it outputs compacted sns and the survivor count. It is a pure combinational popcount/compare per slot.

## Test plan
- **Fill.** Reset, then enqueue slots 0,1,2,3,4,5 one per cycle.
  - Required: sns = 0..5 in slot order, `full`=1, `head`=0.
  - A 7th enqueue sets `err` and leaves state unchanged.
- **Retire middle-to-head.** Start with entries at slots 2,0,5 holding sn 0,1,2.
  - Retire slot 2 → slot 0 sn 0, slot 5 sn 1, `head`=0, `count`=2.
- **Stomp with compaction.** Start with sn 0..5 in slots 0..5.
  - Stomp mask 8'b0001_0100 → slots 0,1,3,5 hold sn 0,1,2,3; slots 2 and 4 hold 6'h3F; `count`=4.
- **Simultaneous retire + stomp + enqueue.** Start full.
  - `ret_slot`=0, stomp slot 5, enqueue into slot 5 in the same cycle.
  - Required: slots 1..4 hold sn 0..3, slot 5 holds sn 4, `err`=0.
- **Dual enqueue (macro defined).** From empty, `enq0_slot`=3 and `enq1_slot`=1 in one cycle → slot 3 sn 0, slot 1 sn 1.
  - The same-slot pair 3,3 → only port 0 is accepted and `err` is set.
- **Async reset mid-stream.** Assert `rst` between clock edges while entries are live.
  - Outputs return to reset values immediately.
  - The next enqueue after release gets sn 0.

Source files
------------

// File: rtl/thor2022_sns_tracker_pkg.sv
// thor2022_sns_tracker_pkg: shared ROB size, sequence-number width, free value and sns array type
package thor2022_sns_tracker_pkg;
  localparam int REB_ENTRIES = 6;
  localparam int SNW = 6;
  localparam logic [SNW-1:0] SN_FREE = '1;
  localparam logic [3:0] REB_N = 4'(REB_ENTRIES);
  localparam logic [7:0] SLOT_MASK = 8'((1 << REB_ENTRIES) - 1);
  typedef logic [0:7][SNW-1:0] sns_arr_t;
endpackage

// File: rtl/thor2022_sns_tracker_if.sv
// thor2022_sns_tracker_if: enq0/enq1 (enq1 only with THOR2022_SNS_DUAL_ENQ_EN), ret, stomp in; sns, live, count, head, full, empty, err out
interface thor2022_sns_tracker_if;
  import thor2022_sns_tracker_pkg::*;
  logic enq0;
  logic [2:0] enq0_slot;
`ifdef THOR2022_SNS_DUAL_ENQ_EN
  logic enq1;
  logic [2:0] enq1_slot;
`endif
  logic ret;
  logic [2:0] ret_slot;
  logic [7:0] stomp;
  sns_arr_t sns;
  logic [7:0] live;
  logic [2:0] count;
  logic [2:0] head;
  logic full;
  logic empty;
  logic err;
  modport master (
    output enq0, enq0_slot,
`ifdef THOR2022_SNS_DUAL_ENQ_EN
    enq1, enq1_slot,
`endif
    ret, ret_slot, stomp,
    input sns, live, count, head, full, empty, err
  );
  modport slave (
    input enq0, enq0_slot,
`ifdef THOR2022_SNS_DUAL_ENQ_EN
    enq1, enq1_slot,
`endif
    ret, ret_slot, stomp,
    output sns, live, count, head, full, empty, err
  );
endinterface

// File: rtl/thor2022_sns_rank.sv
// thor2022_sns_rank: drops stomped slots and re-ranks survivors densely (live_in, sns_in, stomp -> sns_out, live_out, cnt)
module thor2022_sns_rank
  import thor2022_sns_tracker_pkg::*;
(
  input  logic [7:0] live_in,
  input  sns_arr_t   sns_in,
  input  logic [7:0] stomp,
  output sns_arr_t   sns_out,
  output logic [7:0] live_out,
  output logic [2:0] cnt
);
  logic [SNW-1:0] r [8];
  always_comb begin
    live_out = live_in & ~stomp & SLOT_MASK;
    for (int i = 0; i < 8; i++) begin
      r[i] = '0;
      for (int j = 0; j < 8; j++) r[i] = r[i] + SNW'(live_out[j] && sns_in[j] < sns_in[i]);
      sns_out[i] = live_out[i] ? r[i] : SN_FREE;
    end
    cnt = 3'($countones(live_out));
  end
endmodule

// File: rtl/thor2022_sns_tracker.sv
// thor2022_sns_tracker: dense ROB age numbers via retire, stomp, enqueue phases (clk, async rst, bus slave; THOR2022_SNS_DUAL_ENQ_EN adds enq1)
module thor2022_sns_tracker
  import thor2022_sns_tracker_pkg::*;
(
  input logic clk,
  input logic rst,
  thor2022_sns_tracker_if.slave bus
);
  logic [7:0] live_q, live1, live2, live_d;
  sns_arr_t sns_q, sns1, sns2, sns_d;
  logic [2:0] c, count_q, count_d, head_q, head_d, enq1_slot;
  logic [3:0] n1;
  logic ret_ok, e0_ok, e1_ok, enq1, err_q, err_d, full_q, empty_q;
`ifdef THOR2022_SNS_DUAL_ENQ_EN
  assign enq1 = bus.enq1;
  assign enq1_slot = bus.enq1_slot;
`else
  assign enq1 = 1'b0;
  assign enq1_slot = '0;
`endif
  always_comb begin
    ret_ok = bus.ret && live_q[bus.ret_slot];
    live1 = live_q;
    sns1 = sns_q;
    for (int i = 0; i < 8; i++) begin
      if (ret_ok && 3'(i) == bus.ret_slot) begin
        live1[i] = 1'b0;
        sns1[i] = SN_FREE;
      end else if (ret_ok && live_q[i] && sns_q[i] > sns_q[bus.ret_slot]) sns1[i] = sns_q[i] - 1'b1;
    end
  end
  thor2022_sns_rank u_rank (
    .live_in (live1),
    .sns_in  (sns1),
    .stomp   (bus.stomp),
    .sns_out (sns2),
    .live_out(live2),
    .cnt     (c)
  );
  always_comb begin
    e0_ok = bus.enq0 && {1'b0, bus.enq0_slot} < REB_N && !live2[bus.enq0_slot] && {1'b0, c} < REB_N;
    n1 = {1'b0, c} + 4'(e0_ok);
    e1_ok = enq1 && {1'b0, enq1_slot} < REB_N && !live2[enq1_slot] &&
            !(bus.enq0 && bus.enq0_slot == enq1_slot) && n1 < REB_N;
    live_d = live2;
    sns_d = sns2;
    if (e0_ok) begin
      live_d[bus.enq0_slot] = 1'b1;
      sns_d[bus.enq0_slot] = SNW'(c);
    end
    if (e1_ok) begin
      live_d[enq1_slot] = 1'b1;
      sns_d[enq1_slot] = SNW'(n1);
    end
    count_d = 3'(n1 + 4'(e1_ok));
    err_d = err_q || (bus.ret && !ret_ok) || (bus.enq0 && !e0_ok) || (enq1 && !e1_ok);
    head_d = 3'd7;
    for (int i = 7; i >= 0; i--) if (live_d[i] && sns_d[i] == '0) head_d = 3'(i);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      live_q <= '0;
      sns_q <= {8{SN_FREE}};
      count_q <= '0;
      head_q <= 3'd7;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      live_q <= live_d;
      sns_q <= sns_d;
      count_q <= count_d;
      head_q <= head_d;
      full_q <= {1'b0, count_d} == REB_N;
      empty_q <= count_d == '0;
      err_q <= err_d;
    end
  assign bus.live = live_q;
  assign bus.sns = sns_q;
  assign bus.count = count_q;
  assign bus.head = head_q;
  assign bus.full = full_q;
  assign bus.empty = empty_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_thor2022_sns_tracker.sv
// tb_thor2022_sns_tracker: table-driven and directed sequence checks of thor2022_sns_tracker
module tb_thor2022_sns_tracker;
  import thor2022_sns_tracker_pkg::*;
  localparam int F = 63;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  thor2022_sns_tracker_if bus ();
  thor2022_sns_tracker dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic enq0;
    logic [2:0] es;
    logic ret;
    logic [2:0] rs;
    logic [7:0] stomp;
    logic [7:0] live;
    sns_arr_t sns;
    logic [2:0] count;
    logic [2:0] head;
    logic err;
  } vec_t;
  vec_t tbl [12];
  function automatic sns_arr_t S(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {6'(a0), 6'(a1), 6'(a2), 6'(a3), 6'(a4), 6'(a5), 6'(a6), 6'(a7)};
  endfunction
  task automatic idle();
    bus.enq0 = 1'b0;
    bus.enq0_slot = '0;
`ifdef THOR2022_SNS_DUAL_ENQ_EN
    bus.enq1 = 1'b0;
    bus.enq1_slot = '0;
`endif
    bus.ret = 1'b0;
    bus.ret_slot = '0;
    bus.stomp = '0;
  endtask
  task automatic step(input logic e0, input logic [2:0] s0, input logic r, input logic [2:0] rs, input logic [7:0] st);
    @(negedge clk);
    bus.enq0 = e0;
    bus.enq0_slot = s0;
    bus.ret = r;
    bus.ret_slot = rs;
    bus.stomp = st;
    @(posedge clk);
    #1 idle();
  endtask
  task automatic cmp(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic check(input string n, input logic [7:0] l, input sns_arr_t s, input logic [2:0] c, input logic [2:0] h, input logic e);
    cmp({n, " live"}, 64'(bus.live), 64'(l));
    cmp({n, " sns"}, 64'(bus.sns), 64'(s));
    cmp({n, " count"}, 64'(bus.count), 64'(c));
    cmp({n, " head"}, 64'(bus.head), 64'(h));
    cmp({n, " err"}, 64'(bus.err), 64'(e));
    cmp({n, " full"}, 64'(bus.full), 64'(c == 3'd6));
    cmp({n, " empty"}, 64'(bus.empty), 64'(c == 3'd0));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic fill();
    for (int k = 0; k < 6; k++) step(1'b1, 3'(k), 1'b0, 3'd0, 8'h00);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 8'h01, S(0, F, F, F, F, F, F, F), 3'd1, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 3'd1, 1'b0, 3'd0, 8'h00, 8'h03, S(0, 1, F, F, F, F, F, F), 3'd2, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 8'h07, S(0, 1, 2, F, F, F, F, F), 3'd3, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 3'd3, 1'b0, 3'd0, 8'h00, 8'h0F, S(0, 1, 2, 3, F, F, F, F), 3'd4, 3'd0, 1'b0};
    tbl[4]  = '{1'b1, 3'd4, 1'b0, 3'd0, 8'h00, 8'h1F, S(0, 1, 2, 3, 4, F, F, F), 3'd5, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 3'd5, 1'b0, 3'd0, 8'h00, 8'h3F, S(0, 1, 2, 3, 4, 5, F, F), 3'd6, 3'd0, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 1'b0, 3'd0, 8'h14, 8'h2B, S(0, 1, F, 2, F, 3, F, F), 3'd4, 3'd0, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 1'b1, 3'd0, 8'h00, 8'h2A, S(F, 0, F, 1, F, 2, F, F), 3'd3, 3'd1, 1'b0};
    tbl[8]  = '{1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 8'h2E, S(F, 0, 3, 1, F, 2, F, F), 3'd4, 3'd1, 1'b0};
    tbl[9]  = '{1'b0, 3'd0, 1'b1, 3'd3, 8'h80, 8'h26, S(F, 0, 2, F, F, 1, F, F), 3'd3, 3'd1, 1'b0};
    tbl[10] = '{1'b1, 3'd6, 1'b0, 3'd0, 8'h00, 8'h26, S(F, 0, 2, F, F, 1, F, F), 3'd3, 3'd1, 1'b1};
    tbl[11] = '{1'b0, 3'd0, 1'b1, 3'd4, 8'h00, 8'h26, S(F, 0, 2, F, F, 1, F, F), 3'd3, 3'd1, 1'b1};
    idle();
    do_reset();
    check("reset", 8'h00, S(F, F, F, F, F, F, F, F), 3'd0, 3'd7, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].enq0, tbl[k].es, tbl[k].ret, tbl[k].rs, tbl[k].stomp);
      check($sformatf("vec%0d", k), tbl[k].live, tbl[k].sns, tbl[k].count, tbl[k].head, tbl[k].err);
    end
    do_reset();
    step(1'b1, 3'd2, 1'b0, 3'd0, 8'h00);
    step(1'b1, 3'd0, 1'b0, 3'd0, 8'h00);
    step(1'b1, 3'd5, 1'b0, 3'd0, 8'h00);
    check("build", 8'h25, S(1, F, 0, F, F, 2, F, F), 3'd3, 3'd2, 1'b0);
    step(1'b0, 3'd0, 1'b1, 3'd2, 8'h00);
    check("ret_head", 8'h21, S(0, F, F, F, F, 1, F, F), 3'd2, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 3'd0, 8'hFF);
    check("stomp_all", 8'h00, S(F, F, F, F, F, F, F, F), 3'd0, 3'd7, 1'b0);
    step(1'b0, 3'd0, 1'b1, 3'd3, 8'h00);
    check("ret_dead", 8'h00, S(F, F, F, F, F, F, F, F), 3'd0, 3'd7, 1'b1);
    do_reset();
    fill();
    check("fill", 8'h3F, S(0, 1, 2, 3, 4, 5, F, F), 3'd6, 3'd0, 1'b0);
    step(1'b1, 3'd3, 1'b0, 3'd0, 8'h00);
    check("overflow", 8'h3F, S(0, 1, 2, 3, 4, 5, F, F), 3'd6, 3'd0, 1'b1);
    do_reset();
    fill();
    step(1'b1, 3'd5, 1'b1, 3'd0, 8'h20);
    check("ret_stomp_enq", 8'h3E, S(F, 0, 1, 2, 3, 4, F, F), 3'd5, 3'd1, 1'b0);
    step(1'b1, 3'd0, 1'b0, 3'd0, 8'h00);
    check("refill", 8'h3F, S(5, 0, 1, 2, 3, 4, F, F), 3'd6, 3'd1, 1'b0);
    step(1'b1, 3'd1, 1'b1, 3'd1, 8'h00);
    check("ret_enq_full", 8'h3F, S(4, 5, 0, 1, 2, 3, F, F), 3'd6, 3'd2, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_rst", 8'h00, S(F, F, F, F, F, F, F, F), 3'd0, 3'd7, 1'b0);
    rst = 1'b0;
    step(1'b1, 3'd4, 1'b0, 3'd0, 8'h00);
    check("post_rst", 8'h10, S(F, F, F, F, 0, F, F, F), 3'd1, 3'd4, 1'b0);
`ifdef THOR2022_SNS_DUAL_ENQ_EN
    do_reset();
    @(negedge clk);
    bus.enq0 = 1'b1;
    bus.enq0_slot = 3'd3;
    bus.enq1 = 1'b1;
    bus.enq1_slot = 3'd1;
    @(posedge clk);
    #1 idle();
    check("dual", 8'h0A, S(F, 1, F, 0, F, F, F, F), 3'd2, 3'd3, 1'b0);
    @(negedge clk);
    bus.enq0 = 1'b1;
    bus.enq0_slot = 3'd4;
    bus.enq1 = 1'b1;
    bus.enq1_slot = 3'd4;
    @(posedge clk);
    #1 idle();
    check("dual_same", 8'h1A, S(F, 1, F, 0, 2, F, F, F), 3'd3, 3'd3, 1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
